// File: rtl/userio_pkg.sv
// rtl/userio_pkg.sv - shared types and packing helpers for the USERIO pattern sequencer
package userio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_DIVW  = 16;
  localparam int DEF_LOOPW = 16;

  // Pattern word is {oe, data}: data sits at bit 0, oe directly above it.
  localparam int DATA_LSB = 0;

  function automatic int oe_lsb(input int width);
    return DATA_LSB + width;
  endfunction

endpackage

// File: rtl/userio_pat_ram.sv
// rtl/userio_pat_ram.sv - simple dual-port buffer, registered read with write-first bypass
module userio_pat_ram #(
  parameter int pAW = 6,
  parameter int pDW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [pAW-1:0] wr_addr,
  input  logic [pDW-1:0] wr_data,
  input  logic           rd_en,
  input  logic [pAW-1:0] rd_addr,
  output logic [pDW-1:0] rd_data
);

  logic [pDW-1:0] mem [2**pAW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read register doubles as the sequencer output register, so it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/userio_seq.sv
// rtl/userio_seq.sv - USERIO pin block with static drive and pattern sequencer
// Optional capture buffer enabled by defining USERIO_SEQ_CAPTURE_EN.
module userio_seq
  import userio_pkg::*;
#(
  parameter int pWIDTH = DEF_WIDTH,
  parameter int pDEPTH = DEF_DEPTH,
  parameter int pDIVW  = DEF_DIVW,
  parameter int pLOOPW = DEF_LOOPW,
  localparam int pAW   = $clog2(pDEPTH)
) (
  input  logic                  usb_clk,
  input  logic                  reset_n,
  inout  wire  [pWIDTH-1:0]     userio_d,
  input  logic [pWIDTH-1:0]     I_drive_data,
  input  logic [pWIDTH-1:0]     I_pwdriven,
  input  logic [pWIDTH-1:0]     I_pat_sel,
  input  logic                  I_pat_wr,
  input  logic [pAW-1:0]        I_pat_addr,
  input  logic [2*pWIDTH-1:0]   I_pat_wdata,
  input  logic [pAW:0]          I_pat_len,
  input  logic [pDIVW-1:0]      I_divisor,
  input  logic [pLOOPW-1:0]     I_loops,
  input  logic                  I_start,
  input  logic                  I_abort,
  output logic                  O_busy,
  output logic                  O_done,
  output logic [pAW-1:0]        O_step,
  output logic [pWIDTH-1:0]     O_userio_in
`ifdef USERIO_SEQ_CAPTURE_EN
  ,
  input  logic [pAW-1:0]        I_cap_addr,
  output logic [pWIDTH-1:0]     O_cap_rdata
`endif
);

  localparam int OE_LSB = oe_lsb(pWIDTH);

  state_t              state_q, state_d;
  logic [pAW-1:0]      step_q;
  logic [pDIVW-1:0]    cnt_q, div_q;
  logic [pAW:0]        len_q;
  logic [pLOOPW-1:0]   loops_q, left_q;
  logic                rd_en;
  logic [pAW-1:0]      rd_addr;
  logic [2*pWIDTH-1:0] seq_word;
  logic [pWIDTH-1:0]   sync_q1, sync_q2;
  logic                len_ok, step_end, last_step, final_pass;

  assign len_ok     = (I_pat_len != '0) && (I_pat_len <= (pAW+1)'(pDEPTH));
  assign step_end   = (cnt_q == div_q);
  assign last_step  = ({1'b0, step_q} == (len_q - (pAW+1)'(1)));
  assign final_pass = (loops_q != '0) && (left_q == pLOOPW'(1));

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state_q)
      IDLE: begin
        if (I_start && !I_abort && len_ok) begin
          state_d = RUN;
          rd_en   = 1'b1;
        end
      end
      RUN: begin
        if (I_abort) begin
          state_d = IDLE;
        end else if (step_end) begin
          if (last_step && final_pass) begin
            state_d = DONE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = last_step ? '0 : step_q + pAW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      len_q   <= '0;
      loops_q <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == RUN) begin
        div_q   <= I_divisor;
        len_q   <= I_pat_len;
        loops_q <= I_loops;
        left_q  <= I_loops;
        step_q  <= '0;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        if (state_d != RUN) begin
          step_q <= '0;
          cnt_q  <= '0;
        end else if (step_end) begin
          cnt_q  <= '0;
          step_q <= rd_addr;
          // loops==0 means run forever, so the pass counter is left alone
          if (last_step && loops_q != '0) left_q <= left_q - pLOOPW'(1);
        end else begin
          cnt_q <= cnt_q + pDIVW'(1);
        end
      end
    end
  end

  userio_pat_ram #(.pAW(pAW), .pDW(2*pWIDTH)) u_pat_ram (
    .clk     (usb_clk),
    .rst_n   (reset_n),
    .wr_en   (I_pat_wr),
    .wr_addr (I_pat_addr),
    .wr_data (I_pat_wdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (seq_word)
  );

  assign O_busy = (state_q == RUN);
  assign O_done = (state_q == DONE);
  assign O_step = step_q;

  for (genvar i = 0; i < pWIDTH; i++) begin : g_pin
    logic use_seq, pad_oe, pad_do;
    assign use_seq     = O_busy && I_pat_sel[i];
    assign pad_oe      = use_seq ? seq_word[OE_LSB+i]   : I_pwdriven[i];
    assign pad_do      = use_seq ? seq_word[DATA_LSB+i] : I_drive_data[i];
    assign userio_d[i] = pad_oe ? pad_do : 1'bz;
`ifndef __ICARUS__
    pullup pu (userio_d[i]);
`endif
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= userio_d;
      sync_q2 <= sync_q1;
    end
  end
  assign O_userio_in = sync_q2;

`ifdef USERIO_SEQ_CAPTURE_EN
  // Sample on the last clock of each step so the pads have settled for the full step.
  userio_pat_ram #(.pAW(pAW), .pDW(pWIDTH)) u_cap_ram (
    .clk     (usb_clk),
    .rst_n   (reset_n),
    .wr_en   (O_busy && step_end),
    .wr_addr (step_q),
    .wr_data (O_userio_in),
    .rd_en   (1'b1),
    .rd_addr (I_cap_addr),
    .rd_data (O_cap_rdata)
  );
`endif

endmodule

// File: tb/tb_userio_seq.sv
// tb/tb_userio_seq.sv - randomized self-checking bench for userio_seq
module tb_userio_seq;

  localparam int W = 8, D = 64, AW = 6, DIVW = 16, LOOPW = 16;

  logic            usb_clk = 1'b0;
  logic            reset_n = 1'b0;
  wire  [W-1:0]    userio_d;
  logic [W-1:0]    I_drive_data, I_pwdriven, I_pat_sel;
  logic            I_pat_wr;
  logic [AW-1:0]   I_pat_addr;
  logic [2*W-1:0]  I_pat_wdata;
  logic [AW:0]     I_pat_len;
  logic [DIVW-1:0] I_divisor;
  logic [LOOPW-1:0] I_loops;
  logic            I_start, I_abort;
  logic            O_busy, O_done;
  logic [AW-1:0]   O_step;
  logic [W-1:0]    O_userio_in;

  logic [W-1:0] m_oe [D];
  logic [W-1:0] m_d  [D];
  int checks = 0;
  int errors = 0;

  userio_seq dut (
    .usb_clk(usb_clk), .reset_n(reset_n), .userio_d(userio_d),
    .I_drive_data(I_drive_data), .I_pwdriven(I_pwdriven), .I_pat_sel(I_pat_sel),
    .I_pat_wr(I_pat_wr), .I_pat_addr(I_pat_addr), .I_pat_wdata(I_pat_wdata),
    .I_pat_len(I_pat_len), .I_divisor(I_divisor), .I_loops(I_loops),
    .I_start(I_start), .I_abort(I_abort), .O_busy(O_busy), .O_done(O_done),
    .O_step(O_step), .O_userio_in(O_userio_in)
  );

  for (genvar i = 0; i < W; i++) begin : g_pu
    pullup pu (userio_d[i]);
  end

  always #5 usb_clk = ~usb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Board-level view: undriven pins read high through the pull-ups.
  function automatic logic [W-1:0] pad_exp(input logic seq_on, input logic [W-1:0] e_oe, input logic [W-1:0] e_d);
    logic [W-1:0] sel, oe, d;
    sel = seq_on ? I_pat_sel : '0;
    oe  = (sel & e_oe) | (~sel & I_pwdriven);
    d   = (sel & e_d)  | (~sel & I_drive_data);
    return (d & oe) | ~oe;
  endfunction

  task automatic wr_pat(input int a, input logic [W-1:0] oe, input logic [W-1:0] d);
    I_pat_wr = 1'b1; I_pat_addr = AW'(a); I_pat_wdata = {oe, d};
    m_oe[a] = oe; m_d[a] = d;
    @(negedge usb_clk);
    I_pat_wr = 1'b0;
  endtask

  task automatic run_seq(input int len, input int div, input int loops, input bit jitter, input bit byp);
    int total, s;
    I_pat_len = (AW+1)'(len); I_divisor = DIVW'(div); I_loops = LOOPW'(loops);
    I_start = 1'b1;
    if (byp) begin
      I_pat_wr = 1'b1; I_pat_addr = '0;
      m_oe[0] = W'($urandom); m_d[0] = W'($urandom);
      I_pat_wdata = {m_oe[0], m_d[0]};
    end
    @(negedge usb_clk);
    I_start = 1'b0; I_pat_wr = 1'b0;
    total = len * (div + 1) * loops;
    for (int k = 0; k < total; k++) begin
      s = (k / (div + 1)) % len;
      check("run_busy", O_busy, 1);
      check("run_done_low", O_done, 0);
      check("run_step", O_step, s);
      check("run_pads", userio_d, pad_exp(1'b1, m_oe[s], m_d[s]));
      if (jitter && k == 1) begin
        I_start = 1'b1;
        I_pat_len = (AW+1)'($urandom_range(1, D));
        I_divisor = DIVW'($urandom_range(0, 5));
        I_loops = LOOPW'($urandom_range(1, 4));
      end else begin
        I_start = 1'b0;
      end
      @(negedge usb_clk);
    end
    check("end_done", O_done, 1);
    check("end_busy", O_busy, 0);
    check("end_pads_static", userio_d, pad_exp(1'b0, '0, '0));
    I_start = jitter;
    I_pat_len = (AW+1)'(len);
    @(negedge usb_clk);
    I_start = 1'b0;
    check("done_one_cycle", O_done, 0);
    check("start_in_done_ignored", O_busy, 0);
  endtask

  initial begin
    I_drive_data = '0; I_pwdriven = '0; I_pat_sel = '0;
    I_pat_wr = 1'b0; I_pat_addr = '0; I_pat_wdata = '0;
    I_pat_len = '0; I_divisor = '0; I_loops = '0;
    I_start = 1'b0; I_abort = 1'b0;
    for (int i = 0; i < D; i++) begin m_oe[i] = '0; m_d[i] = '0; end

    repeat (2) @(negedge usb_clk);
    check("rst_busy", O_busy, 0);
    check("rst_done", O_done, 0);
    check("rst_step", O_step, 0);
    check("rst_in", O_userio_in, 0);
    check("rst_pads", userio_d, 8'hFF);
    reset_n = 1'b1;
    repeat (3) @(negedge usb_clk);
    check("idle_in", O_userio_in, 8'hFF);

    I_pwdriven = 8'h0F; I_drive_data = 8'hA5;
    #1 check("static_pads", userio_d, 8'hF5);
    @(negedge usb_clk);
    check("sync_lat1", O_userio_in, 8'hFF);
    @(negedge usb_clk);
    check("sync_lat2", O_userio_in, 8'hF5);

    wr_pat(0, 8'hFF, 8'h01); wr_pat(1, 8'hFF, 8'h02);
    wr_pat(2, 8'hFF, 8'h04); wr_pat(3, 8'hFF, 8'h08);
    I_pat_sel = 8'hFF;
    run_seq(4, 2, 2, 1'b0, 1'b0);

    I_pat_sel = 8'h0F; I_drive_data = 8'h00; I_pwdriven = 8'hF0;
    wr_pat(5, 8'hFF, 8'hFF);
    I_pat_len = 7'd1; I_divisor = 16'd1; I_loops = 16'd1; I_start = 1'b1;
    I_pat_wr = 1'b1; I_pat_addr = 6'd0; I_pat_wdata = 16'hFFFF;
    m_oe[0] = 8'hFF; m_d[0] = 8'hFF;
    @(negedge usb_clk);
    I_start = 1'b0; I_pat_wr = 1'b0;
    check("mixed_pads", userio_d, 8'h0F);
    repeat (3) @(negedge usb_clk);

    I_pat_sel = 8'hFF; I_pwdriven = 8'h00;
    wr_pat(0, 8'hFF, 8'h55); wr_pat(1, 8'hFF, 8'hAA);
    I_pat_len = 7'd2; I_divisor = 16'd0; I_loops = 16'd0; I_start = 1'b1;
    @(negedge usb_clk);
    I_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("inf_pads", userio_d, (k % 2 == 0) ? 8'h55 : 8'hAA);
      check("inf_done_low", O_done, 0);
      @(negedge usb_clk);
    end
    I_abort = 1'b1;
    @(negedge usb_clk);
    I_abort = 1'b0;
    check("abort_busy", O_busy, 0);
    check("abort_pads", userio_d, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      check("abort_no_done", O_done, 0);
      @(negedge usb_clk);
    end

    I_pat_len = 7'd0; I_start = 1'b1;
    @(negedge usb_clk);
    I_start = 1'b0;
    check("len0_busy", O_busy, 0);
    I_pat_len = 7'd65; I_start = 1'b1;
    @(negedge usb_clk);
    I_start = 1'b0;
    check("len65_busy", O_busy, 0);
    I_pat_len = 7'd64; I_start = 1'b1; I_abort = 1'b1;
    @(negedge usb_clk);
    I_start = 1'b0; I_abort = 1'b0;
    check("start_abort_idle", O_busy, 0);

    I_pat_len = 7'd4; I_divisor = 16'd2; I_loops = 16'd2; I_start = 1'b1;
    @(negedge usb_clk);
    I_start = 1'b0;
    repeat (5) @(negedge usb_clk);
    check("pre_reset_busy", O_busy, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", O_busy, 0);
    check("midrst_step", O_step, 0);
    check("midrst_pads", userio_d, 8'hFF);
    @(negedge usb_clk);
    reset_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      check("midrst_no_done", O_done, 0);
      @(negedge usb_clk);
    end

    for (int it = 0; it < 8; it++) begin
      int len, div, loops;
      len = $urandom_range(1, 8);
      div = $urandom_range(0, 3);
      loops = $urandom_range(1, 3);
      I_pat_sel = W'($urandom); I_drive_data = W'($urandom); I_pwdriven = W'($urandom);
      for (int a = 0; a < len; a++) wr_pat(a, W'($urandom), W'($urandom));
      run_seq(len, div, loops, 1'b1, it[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
